inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall_i  in  1  downstream hold; head entry not consumed while high.
REQ-005 branch_flag_i  in  1  redirect request from decode.
REQ-006 branch_target_i  in  32  redirect address; bits [1:0] ignored, treated as 00.
REQ-007 imem_req_o  out  1  fetch request valid.
REQ-008 imem_addr_o  out  32  fetch address, word aligned.
REQ-009 imem_gnt_i  in  1  memory accepts request this cycle when imem_req_o=1.
REQ-010 imem_rvalid_i  in  1  read data valid; responses in request order, latency >= 1 cycle.
REQ-011 imem_rdata_i  in  32  instruction word.
REQ-012 if_pc_o  out  32  PC of presented instruction, to IF/ID register.
REQ-013 if_inst_o  out  32  presented instruction.
REQ-014 if_valid_o  out  1  if_pc_o/if_inst_o valid.

Function
REQ-015 The block SHALL hold a PC register; imem_addr_o = PC.
REQ-016 The block SHALL hold a 2-entry FIFO of {pc, inst}, plus a 2-entry in-order queue of PCs for outstanding requests.
REQ-017 Credit rule: imem_req_o SHALL be 1 iff (FIFO count + outstanding count) < 2 and branch_flag_i = 0.
REQ-018 Request accepted (req & gnt): PC <= PC + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), PC pushed to the outstanding queue.
REQ-019 imem_rvalid_i with no pending discards: pop outstanding PC, push {pc, imem_rdata_i} into FIFO.
REQ-020 Outputs SHALL present FIFO head; if_valid_o = FIFO not empty; entry popped when if_valid_o & !stall_i.
REQ-021 Simultaneous push and pop SHALL keep the count unchanged; the credit rule guarantees no push into a full FIFO.
REQ-022 When stall_i=1 with a full FIFO, requests SHALL cease and the head SHALL remain stable.
REQ-023 branch_flag_i=1: PC <= {branch_target_i[31:2],2'b00}; FIFO flushed; all outstanding requests marked discard; if_valid_o = 0 the next cycle.
REQ-024 Responses to discarded requests SHALL be dropped (discard count decremented) and never appear on the outputs.
REQ-025 Branch in the same cycle as rvalid: response dropped; branch in the same cycle as a FIFO pop: flush wins.
REQ-026 Priority: rst > branch_flag_i > normal fetch/consume.
REQ-027 imem_rvalid_i with zero outstanding requests SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately set PC=RESET_PC, FIFO empty, outstanding/discard counts 0, imem_req_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
REQ-029 Reset asserted mid-fetch SHALL abandon all requests; the first cycle after release SHALL drive imem_req_o=1, imem_addr_o=RESET_PC.

Configuration
REQ-030 Macro FETCH_BYPASS_EN defined: a response arriving with FIFO empty and stall_i=0 SHALL be presented combinationally the same cycle (if_valid_o=1) and not stored.
REQ-031 FETCH_BYPASS_EN undefined: every response SHALL enter the FIFO and become visible the following cycle; outputs then come only from registers.

Verification
REQ-032 Reset release, gnt=1 always, 1-cycle latency, data = addr -> if_pc_o sequence 0,4,8,C with if_inst_o equal to the PC, one per cycle after fill.
REQ-033 stall_i held high 5 cycles -> at most 2 requests issued, imem_req_o=0 thereafter, head (pc=0) stable; release -> 4,8 follow without gaps or duplicates.
REQ-034 Two requests outstanding (0,4), branch_flag_i=1 target 32'h0000_0102 -> next request addr 0x100; responses for 0,4 dropped; first if_valid_o shows pc=0x100.
REQ-035 Branch in the same cycle as rvalid and pop -> no output with old PC, FIFO empty next cycle.
REQ-036 rst pulsed while 2 requests outstanding -> all outputs 0 asynchronously, late rvalid ignored, refetch from RESET_PC.
REQ-037 PC at 32'hFFFF_FFFC granted -> next imem_addr_o = 0; run with and without FETCH_BYPASS_EN, checking the 0/1-cycle response-to-output latency.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: word-aligned PC register, a 2-entry FIFO of fetched
// {pc, inst} pairs, and a 2-entry in-order queue that holds the PCs of
// outstanding memory requests. Total credit is two entries. The credit counts
// fetched entries, outstanding requests and requests already marked for discard.
// On a branch the PC is redirected, the FIFO is flushed, and every outstanding
// response is discarded.
// Optional feature: define FETCH_BYPASS_EN so that a response that arrives
// while the FIFO is empty and downstream is not stalled is presented in the
// same cycle, without being stored.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Control state (reset)
  logic [31:0] pc_q, pc_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  logic        fifo_rd_q, fifo_rd_d;
  logic        fifo_wr_q, fifo_wr_d;
  logic [1:0]  osd_cnt_q, osd_cnt_d;
  logic        osd_rd_q, osd_rd_d;
  logic        osd_wr_q, osd_wr_d;
  logic [1:0]  dsc_cnt_q, dsc_cnt_d;

  // Payload storage (not reset)
  fetch_entry_t [1:0]       fifo_q, fifo_d;
  logic         [1:0][31:0] osd_q, osd_d;

  // Datapath helpers
  logic [2:0]  in_flight;
  logic        req_acc;
  logic        rsp_drop;
  logic        rsp_take;
  logic [31:0] rsp_pc;
  logic        fifo_empty;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [1:0]  osd_after;
  logic [1:0]  dsc_after;

  assign in_flight  = {1'b0, fifo_cnt_q} + {1'b0, osd_cnt_q} + {1'b0, dsc_cnt_q};
  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign rsp_pc     = osd_q[osd_rd_q];

  // Responses retire discards first, because discarded requests are always
  // older than any live outstanding request. A response that arrives with
  // nothing outstanding is ignored.
  assign rsp_drop = imem_rvalid_i && (dsc_cnt_q != 2'd0);
  assign rsp_take = imem_rvalid_i && (dsc_cnt_q == 2'd0) && (osd_cnt_q != 2'd0);

  // Request only while credit remains and no redirect is pending. The reset
  // term keeps the request low asynchronously while rst is asserted.
  assign imem_req_o  = !rst && (in_flight < 3'd2) && !branch_flag_i;
  assign imem_addr_o = pc_q;
  assign req_acc     = imem_req_o && imem_gnt_i;

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_take && fifo_empty && !stall_i && !branch_flag_i;
`else
  assign bypass = 1'b0;
`endif

  // A redirect flushes the FIFO, so a pop in the same cycle is irrelevant.
  // A response that arrives with a redirect is dropped and not pushed.
  assign pop  = !fifo_empty && !stall_i;
  assign push = rsp_take && !branch_flag_i && !bypass;

  // Present the FIFO head or the bypassed response; drive zeros when nothing is valid.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    if_valid_o = 1'b0;
    if_pc_o    = 32'h0;
    if_inst_o  = 32'h0;
    if (!fifo_empty) begin
      if_valid_o = 1'b1;
      if_pc_o    = fifo_q[fifo_rd_q].pc;
      if_inst_o  = fifo_q[fifo_rd_q].inst;
    end else if (bypass) begin
      if_valid_o = 1'b1;
      if_pc_o    = rsp_pc;
      if_inst_o  = imem_rdata_i;
    end
  end

  // Next-state computation: redirect takes priority over normal fetch/consume.
  always_comb begin
    pc_d       = pc_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    osd_cnt_d  = osd_cnt_q;
    osd_rd_d   = osd_rd_q;
    osd_wr_d   = osd_wr_q;
    dsc_cnt_d  = dsc_cnt_q;
    fifo_d     = fifo_q;
    osd_d      = osd_q;

    osd_after = osd_cnt_q - {1'b0, rsp_take};
    dsc_after = dsc_cnt_q - {1'b0, rsp_drop};
    if (rsp_take) begin
      osd_rd_d = ~osd_rd_q;
    end

    if (branch_flag_i) begin
      pc_d       = branch_target_i & 32'hFFFF_FFFC;
      fifo_cnt_d = 2'd0;
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
      osd_cnt_d  = 2'd0;
      osd_rd_d   = 1'b0;
      osd_wr_d   = 1'b0;
      dsc_cnt_d  = dsc_after + osd_after;
    end else begin
      if (req_acc) begin
        pc_d            = pc_q + 32'd4;
        osd_d[osd_wr_q] = pc_q;
        osd_wr_d        = ~osd_wr_q;
      end
      osd_cnt_d = osd_after + {1'b0, req_acc};
      dsc_cnt_d = dsc_after;

      if (push) begin
        fifo_d[fifo_wr_q] = '{pc: rsp_pc, inst: imem_rdata_i};
        fifo_wr_d         = ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_d = ~fifo_rd_q;
      end
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    if (rst) begin
      pc_q       <= RESET_PC;
      fifo_cnt_q <= 2'd0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      osd_cnt_q  <= 2'd0;
      osd_rd_q   <= 1'b0;
      osd_wr_q   <= 1'b0;
      dsc_cnt_q  <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      fifo_cnt_q <= fifo_cnt_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      osd_cnt_q  <= osd_cnt_d;
      osd_rd_q   <= osd_rd_d;
      osd_wr_q   <= osd_wr_d;
      dsc_cnt_q  <= dsc_cnt_d;
    end
  end

  // Payload registers for FIFO entries and outstanding PCs.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is left without a reset. It is only read behind
    // the reset count/valid state, and the outputs are forced to zero when empty.
    fifo_q <= fifo_d;
    osd_q  <= osd_d;
  end

endmodule
